countdown_timer: RTL
====================

# countdown_timer

Loadable down-counter with start/stop control, terminal-count pulse and optional auto-reload. It complements the free-running up-counter. Software or a controlling FSM loads a cycle count. The block then counts it down to zero and signals expiry with a one-cycle `done` pulse. It is used for timeouts, periodic ticks and delay generation.

## Interface
- `SIZE`, default 8: width of the count and reload value.

- `clk`  in  1  system clock, all state updates on rising edge
- `res_n`  in  1  asynchronous active-low reset
- `load`  in  1  load `load_value` into count and reload register
- `load_value`  in  SIZE  value taken on `load`
- `start`  in  1  start or resume counting
- `stop`  in  1  pause counting; count is held
- `clear`  in  1  synchronous clear to idle, count 0
- `auto_reload`  in  1  on expiry, restart from the reload register instead of stopping
- `value`  out  SIZE  current count (registered)
- `running`  out  1  high while in RUN
- `paused`  out  1  high while in PAUSED
- `done`  out  1  one-cycle expiry pulse (registered)

## Operation
- Clock and reset: one clock `clk`; reset `res_n` is asynchronous and active-low.
- Reset values:
  - `value` = 0, reload register = 0, state IDLE.
  - `done`, `running` and `paused` are all 0.
- States: IDLE, RUN, PAUSED. `running` = (state==RUN) and `paused` = (state==PAUSED), both decoded from the state register.
- Priority per cycle is clear > load > stop > start > decrement.
- `clear`, from any state: `value` <= 0 and state <= IDLE. The reload register is kept and `done` stays 0.
- `load`, from any state: `value` <= `load_value` and reload register <= `load_value`.
  - There is no decrement in that cycle.
  - The state is unchanged, except in RUN: if `load_value` == 0, state <= IDLE with no `done`.
  - `start`/`stop` asserted in the same cycle as `load` are still evaluated after the load.
- `stop`: RUN -> PAUSED. In IDLE or PAUSED it has no effect. When `stop` and `start` are both asserted, `stop` wins.
- `start` from IDLE or PAUSED:
  - With `value` != 0 (after any same-cycle load): state <= RUN.
  - With `value` == 0: `done` <= 1 for one cycle and state stays IDLE (immediate expiry).
- `start` in RUN: ignored.
- RUN with `value` > 1: `value` <= `value` - 1.
- RUN with `value` == 1, which is expiry:
  - `done` <= 1.
  - If `auto_reload` && reload register != 0: `value` <= reload register and state stays RUN.
  - Otherwise: `value` <= 0 and state <= IDLE.
- Arithmetic is unsigned SIZE-bit. `value` never wraps below 0, because RUN is never entered or held with `value` == 0.
- `done` is 0 in every cycle not listed above.
- `auto_reload` is sampled only at expiry and may change at any time.

## Timing
- Start latency: `start` sampled at edge t puts the block in RUN after t. The first decrement is at edge t+1.
- Expiry: with count N at start, `value` reaches 0 and `done` is high after edge t+N. `done` lasts exactly one cycle.
- Auto-reload period: with reload R, `done` pulses every R cycles, e.g. R=1 gives `done` high every cycle.
- Pause: during PAUSED, `value` is frozen. Resume continues from the frozen value, one cycle after the `start` edge.
- Reset mid-count: all outputs return to reset values asynchronously, including a `done` pulse in flight. There is no expiry after release.

## Test plan
- Reset: load 5 and start, then assert `res_n`=0 mid-count -> `value`=0, `running`=0 and `done`=0 immediately, with no `done` after release.
- Load 3, start at edge t -> `value` is 3,2,1,0 after edges t..t+3. `done`=1 only after t+3, then IDLE with `running`=0.
- Load 4, start, stop after 2 decrements (`value`=2) and hold 5 cycles -> `value` stays 2 and `paused`=1. Then start -> `value` is 1, then 0 with `done` pulse.
- Load 3 with `auto_reload`=1, start -> `done` pulses every 3 cycles and `value` cycles 3,2,1,3,2,1…. Deassert `auto_reload` -> stops at 0 after the next expiry.
- Simultaneous events:
  - `clear`+`load`+`start` -> IDLE with `value`=0.
  - `start`+`stop` in IDLE -> stays IDLE.
  - `load` 0 during RUN -> IDLE and no `done`.
  - `start` with `value`=0 -> single `done` pulse and stays IDLE.
- SIZE=4: load 15, start -> 15 decrements to 0, `done` after edge t+15, with no wrap to 15 afterwards.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the controller drives load/start/stop/clear,
// the timer returns its count, run/pause status and the expiry pulse.
interface countdown_timer_if #(
    parameter int SIZE = 8
);
    logic            load;
    logic [SIZE-1:0] load_value;
    logic            start;
    logic            stop;
    logic            clear;
    logic            auto_reload;
    logic [SIZE-1:0] value;
    logic            running;
    logic            paused;
    logic            done;

    modport master (
        output load,
        output load_value,
        output start,
        output stop,
        output clear,
        output auto_reload,
        input  value,
        input  running,
        input  paused,
        input  done
    );

    modport slave (
        input  load,
        input  load_value,
        input  start,
        input  stop,
        input  clear,
        input  auto_reload,
        output value,
        output running,
        output paused,
        output done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop, one-cycle terminal-count pulse and optional auto-reload.
//
// state  | meaning
// IDLE   | not counting; value is whatever was last loaded or 0 after expiry/clear
// RUN    | value decrements each cycle; expiry when value == 1
// PAUSED | value frozen until start
module countdown_timer #(
    parameter int SIZE = 8
) (
    input  logic               clk,
    input  logic               res_n,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_eff;
    logic [SIZE-1:0] value_q;
    logic [SIZE-1:0] reload_q;
    logic [SIZE-1:0] value_eff;
    logic            done_q;

    // A same-cycle load is visible to start/stop; loading 0 while running drops back to IDLE.
    always_comb begin
        value_eff = value_q;
        state_eff = state;
        if (bus.load) begin
            value_eff = bus.load_value;
            if ((state == RUN) && (bus.load_value == '0)) begin
                state_eff = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= IDLE;
            value_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                value_q <= '0;
                state   <= IDLE;
            end else begin
                if (bus.load) begin
                    value_q  <= bus.load_value;
                    reload_q <= bus.load_value;
                    state    <= state_eff;
                end

                if (bus.stop) begin
                    if (state_eff == RUN) begin
                        state <= PAUSED;
                    end
                end else if (bus.start && (state_eff != RUN)) begin
                    if (value_eff != '0) begin
                        state <= RUN;
                    end else begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end else if (!bus.load && (state == RUN)) begin
                    if (value_q > SIZE'(1)) begin
                        value_q <= value_q - SIZE'(1);
                    end else if (value_q == SIZE'(1)) begin
                        done_q <= 1'b1;
                        if (bus.auto_reload && (reload_q != '0)) begin
                            value_q <= reload_q;
                        end else begin
                            value_q <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        // Unreachable guard: never sit in RUN with a zero count.
                        state <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.value   = value_q;
    assign bus.done    = done_q;
    assign bus.running = (state == RUN);
    assign bus.paused  = (state == PAUSED);

endmodule
